debug_trace_hex: RTL and testbench

- Parametrised successor to the board-level hex debug mux. It captures CPU fetch addresses into a circular history buffer of DEPTH entries.
- It freezes capture on a manual request or an address breakpoint, and lets the operator step backward and forward through the history.
- It drives one AW-bit value to the SEG7 display driver, selected either from NCH live channels or from the history.
- It sits in the board top level, between the bk0010 debug outputs and the SEG7 driver, clocked on the system clock with a CPU-cycle enable.

---
 rtl/debug_trace_hex.sv | 224 ++++++++++++++++++++++
 tb/tb_debug_trace_hex.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_hex.sv
// debug_trace_hex: live-channel / fetch-history hex debug mux.
// Captures channel 0 (fetch address) into a circular history on every
// qualified fetch, freezes on a manual request or address breakpoint,
// and lets the operator walk the frozen history back and forth while the
// selected value is driven, registered, to the SEG7 driver.
module debug_trace_hex #(
  parameter  int AW    = 16,
  parameter  int NCH   = 4,
  parameter  int DEPTH = 16,
  localparam int CSW   = $clog2(NCH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              inst,
  input  logic [NCH*AW-1:0] ch_data,
  input  logic [CSW-1:0]    ch_sel,
  input  logic              disp_hist,
  input  logic              bp_en,
  input  logic [AW-1:0]     bp_addr,
  input  logic              btn_freeze,
  input  logic              btn_run,
  input  logic              btn_back,
  input  logic              btn_fwd,
  output logic [AW-1:0]     hex_value,
  output logic              frozen,
  output logic              hit,
  output logic [PW-1:0]     view_off,
  output logic [PW:0]       count
);

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX   = (PW+1)'(DEPTH);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            hit_q, hit_d;
  logic [PW-1:0]   view_off_q, view_off_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW:0]     count_q, count_d;
  logic [AW-1:0]   hex_value_q, hex_value_d;

  // History storage; not reset, the valid count hides stale contents.
  logic [AW-1:0]   hist_mem [DEPTH];

  // Unpacked view of the live channels.
  logic [AW-1:0]   ch_arr [NCH];

  // FSM-derived control strobes.
  logic            run_mode;
  logic            capture_evt;
  logic            bp_hit;
  logic            freeze_req;
  logic            step_en;

  // Stepping limits and read-side signals.
  logic            back_ok;
  logic            fwd_ok;
  logic [PW-1:0]   ridx_d;
  logic [AW-1:0]   hist_rd;
  logic [AW-1:0]   hist_val;
  logic [AW-1:0]   live_val;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_arr[gi] = ch_data[gi*AW +: AW];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // Hold RUN/FROZEN state across cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  // btn_run dominates: in RUN it also suppresses a same-cycle freeze.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (!btn_run && (btn_freeze || bp_hit)) begin
          state_d = ST_FROZEN;
        end
      end
      ST_FROZEN: begin
        if (btn_run) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------
  // Decode capture, breakpoint and stepping qualifiers from current state.
  always_comb begin
    run_mode    = (state_q == ST_RUN);
    capture_evt = run_mode & ce & inst;
    bp_hit      = capture_evt & bp_en & (ch_arr[0] == bp_addr);
    freeze_req  = run_mode & ~btn_run & (btn_freeze | bp_hit);
    step_en     = ~run_mode & ~btn_run;
  end

  // ---------------------------------------------------------------------
  // Write pointer and valid count
  // ---------------------------------------------------------------------
  // Advance on each capture; DEPTH is a power of two so the pointer wraps
  // naturally, while the count saturates at DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    if (capture_evt) begin
      wptr_d = wptr_q + PTR_ONE;
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Breakpoint flag and history view offset
  // ---------------------------------------------------------------------
  // hit records why we froze; view_off walks history only while frozen.
  always_comb begin
    back_ok    = (count_q > CNT_ONE) && ({1'b0, view_off_q} < (count_q - CNT_ONE));
    fwd_ok     = (view_off_q != '0);
    hit_d      = hit_q;
    view_off_d = view_off_q;
    if (btn_run) begin
      hit_d      = 1'b0;
      view_off_d = '0;
    end else if (freeze_req) begin
      hit_d = bp_hit;
    end else if (step_en && (btn_back ^ btn_fwd)) begin
      if (btn_back && back_ok) begin
        view_off_d = view_off_q + PTR_ONE;
      end else if (btn_fwd && fwd_ok) begin
        view_off_d = view_off_q - PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // History buffer write port
  // ---------------------------------------------------------------------
  // Store the fetch address at the write pointer on each capture.
  always_ff @(posedge clk) begin
    if (capture_evt) begin
      hist_mem[wptr_q] <= ch_arr[0];
    end
  end

  // ---------------------------------------------------------------------
  // Display selection
  // ---------------------------------------------------------------------
  // The display is built from next-cycle pointer/offset/count so that it
  // always matches the registered status outputs. When the entry being
  // read is the one being written this cycle, the incoming fetch address
  // is forwarded so the newest capture is shown immediately.
  always_comb begin
    ridx_d   = wptr_d - PTR_ONE - view_off_d;
    hist_rd  = hist_mem[ridx_d];
    hist_val = hist_rd;
    if (capture_evt && (ridx_d == wptr_q)) begin
      hist_val = ch_arr[0];
    end
    if (count_d == '0) begin
      hist_val = '0;
    end

    live_val = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_sel == CSW'(k)) begin
        live_val = ch_arr[k];
      end
    end

    hex_value_d = disp_hist ? hist_val : live_val;
  end

  // ---------------------------------------------------------------------
  // Status and display registers
  // ---------------------------------------------------------------------
  // Register all operator-visible state; asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q       <= 1'b0;
      view_off_q  <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      hex_value_q <= '0;
    end else begin
      hit_q       <= hit_d;
      view_off_q  <= view_off_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      hex_value_q <= hex_value_d;
    end
  end

  assign hex_value = hex_value_q;
  assign frozen    = (state_q == ST_FROZEN);
  assign hit       = hit_q;
  assign view_off  = view_off_q;
  assign count     = count_q;

endmodule

// File: tb/tb_debug_trace_hex.sv
// Directed testbench for debug_trace_hex: reset, live select, history
// wrap and stepping, breakpoint freeze, step limits and button priority.
module tb_debug_trace_hex;

  localparam int AW    = 16;
  localparam int NCH   = 4;
  localparam int DEPTH = 16;
  localparam int CSW   = $clog2(NCH);
  localparam int PW    = $clog2(DEPTH);

  logic              clk;
  logic              reset_n;
  logic              ce;
  logic              inst;
  logic [NCH*AW-1:0] ch_data;
  logic [3*AW-1:0]   ch_data3;
  logic [CSW-1:0]    ch_sel;
  logic              disp_hist;
  logic              bp_en;
  logic [AW-1:0]     bp_addr;
  logic              btn_freeze;
  logic              btn_run;
  logic              btn_back;
  logic              btn_fwd;

  logic [AW-1:0]     hex_value;
  logic              frozen;
  logic              hit;
  logic [PW-1:0]     view_off;
  logic [PW:0]       count;

  logic [AW-1:0]     hex_value3;
  logic              frozen3;
  logic              hit3;
  logic [PW-1:0]     view_off3;
  logic [PW:0]       count3;

  int n_vec = 0;
  int n_err = 0;

  debug_trace_hex #(.AW(AW), .NCH(NCH), .DEPTH(DEPTH)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .inst       (inst),
    .ch_data    (ch_data),
    .ch_sel     (ch_sel),
    .disp_hist  (disp_hist),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .btn_freeze (btn_freeze),
    .btn_run    (btn_run),
    .btn_back   (btn_back),
    .btn_fwd    (btn_fwd),
    .hex_value  (hex_value),
    .frozen     (frozen),
    .hit        (hit),
    .view_off   (view_off),
    .count      (count)
  );

  // Three-channel instance for the out-of-range select case.
  debug_trace_hex #(.AW(AW), .NCH(3), .DEPTH(DEPTH)) u_dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .inst       (inst),
    .ch_data    (ch_data3),
    .ch_sel     (ch_sel),
    .disp_hist  (disp_hist),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .btn_freeze (btn_freeze),
    .btn_run    (btn_run),
    .btn_back   (btn_back),
    .btn_fwd    (btn_fwd),
    .hex_value  (hex_value3),
    .frozen     (frozen3),
    .hit        (hit3),
    .view_off   (view_off3),
    .count      (count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one edge; return 1ns after it so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_back();
    btn_back = 1'b1;
    tick();
    btn_back = 1'b0;
    tick();
  endtask

  task automatic pulse_fwd();
    btn_fwd = 1'b1;
    tick();
    btn_fwd = 1'b0;
    tick();
  endtask

  task automatic fetch(input logic [AW-1:0] addr);
    ch_data[AW-1:0] = addr;
    ce   = 1'b1;
    inst = 1'b1;
    tick();
  endtask

  task automatic idle();
    ce   = 1'b0;
    inst = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    ce         = 1'b0;
    inst       = 1'b0;
    ch_data    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    ch_data3   = {16'h3333, 16'h2222, 16'h1111};
    ch_sel     = '0;
    disp_hist  = 1'b0;
    bp_en      = 1'b0;
    bp_addr    = '0;
    btn_freeze = 1'b0;
    btn_run    = 1'b0;
    btn_back   = 1'b0;
    btn_fwd    = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // ---- reset mid-capture ----
    for (int i = 0; i < 5; i++) fetch(16'h0A00 + 16'(i));
    chk("count_before_reset", 32'(count), 32'd5);
    #2 reset_n = 1'b0;
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);
    chk("rst_hex", 32'(hex_value), 32'd0);
    chk("rst_view_off", 32'(view_off), 32'd0);
    reset_n   = 1'b1;
    idle();
    disp_hist = 1'b1;
    tick();
    chk("rst_hist_empty", 32'(hex_value), 32'd0);

    // ---- live select ----
    ch_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    disp_hist = 1'b0;
    ch_sel    = 2'd2;
    tick();
    chk("live_sel2", 32'(hex_value), 32'h3333);
    chk("live3_sel2", 32'(hex_value3), 32'h3333);
    ch_sel = 2'd3;
    tick();
    chk("live_sel3", 32'(hex_value), 32'h4444);
    chk("live3_sel3_oob", 32'(hex_value3), 32'h0000);
    ch_sel = 2'd0;
    tick();
    chk("live_sel0", 32'(hex_value), 32'h1111);

    // ---- wrap: 20 fetches into 16 entries ----
    for (int i = 0; i < 20; i++) fetch(16'h1000 + 16'(i));
    idle();
    btn_freeze = 1'b1;
    disp_hist  = 1'b1;
    tick();
    btn_freeze = 1'b0;
    tick();
    chk("wrap_frozen", 32'(frozen), 32'd1);
    chk("wrap_hit", 32'(hit), 32'd0);
    chk("wrap_count", 32'(count), 32'd16);
    chk("wrap_newest", 32'(hex_value), 32'h1013);
    pulse_back();
    chk("wrap_off1", 32'(view_off), 32'd1);
    chk("wrap_off1_hex", 32'(hex_value), 32'h1012);
    for (int i = 0; i < 14; i++) pulse_back();
    chk("wrap_off15", 32'(view_off), 32'd15);
    chk("wrap_oldest", 32'(hex_value), 32'h1004);
    pulse_back();
    chk("wrap_back_hold", 32'(view_off), 32'd15);
    chk("wrap_back_hold_hex", 32'(hex_value), 32'h1004);
    btn_run = 1'b1;
    tick();
    btn_run = 1'b0;
    chk("wrap_run_frozen", 32'(frozen), 32'd0);
    chk("wrap_run_off", 32'(view_off), 32'd0);

    // ---- breakpoint ----
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bp_en   = 1'b1;
    bp_addr = 16'h0140;
    tick();
    fetch(16'h0100);
    fetch(16'h0120);
    chk("bp_not_yet", 32'(frozen), 32'd0);
    fetch(16'h0140);
    chk("bp_frozen", 32'(frozen), 32'd1);
    chk("bp_hit", 32'(hit), 32'd1);
    fetch(16'h0160);
    idle();
    tick();
    chk("bp_count", 32'(count), 32'd3);
    chk("bp_newest", 32'(hex_value), 32'h0140);

    // ---- step limits ----
    for (int i = 0; i < 4; i++) pulse_back();
    chk("step_back_lim", 32'(view_off), 32'd2);
    chk("step_oldest", 32'(hex_value), 32'h0100);
    btn_back = 1'b1;
    btn_fwd  = 1'b1;
    tick();
    btn_back = 1'b0;
    btn_fwd  = 1'b0;
    chk("step_both", 32'(view_off), 32'd2);
    for (int i = 0; i < 3; i++) pulse_fwd();
    chk("step_fwd_lim", 32'(view_off), 32'd0);
    chk("step_fwd_hex", 32'(hex_value), 32'h0140);

    // ---- priority ----
    pulse_back();
    pulse_back();
    chk("prio_off2", 32'(view_off), 32'd2);
    chk("prio_hit_kept", 32'(hit), 32'd1);
    btn_run  = 1'b1;
    btn_back = 1'b1;
    tick();
    btn_run  = 1'b0;
    btn_back = 1'b0;
    chk("prio_frozen", 32'(frozen), 32'd0);
    chk("prio_hit", 32'(hit), 32'd0);
    chk("prio_off", 32'(view_off), 32'd0);
    pulse_back();
    chk("prio_back_in_run", 32'(view_off), 32'd0);

    // run together with a breakpoint fetch: captured, no freeze
    bp_addr = 16'h0200;
    btn_run = 1'b1;
    fetch(16'h0200);
    btn_run = 1'b0;
    idle();
    chk("runbp_frozen", 32'(frozen), 32'd0);
    chk("runbp_count", 32'(count), 32'd4);
    chk("runbp_hex", 32'(hex_value), 32'h0200);

    // RUN tracking: newest capture visible right after its write edge
    bp_en = 1'b0;
    fetch(16'h0300);
    chk("track_0300", 32'(hex_value), 32'h0300);
    fetch(16'h0301);
    chk("track_0301", 32'(hex_value), 32'h0301);
    idle();
    tick();
    chk("track_count", 32'(count), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
